// File: rtl/arm_regfile_sb.sv
// ARM-style register file with a load scoreboard.
//   Two combinational read ports (A/B), one synchronous writeback port and a
//   dedicated link port that writes LR_IDX. PC_IDX is never stored: reads of it
//   return pc_in, and writes to it are redirected out on pc_write/pc_wdata.
//   A per-register busy bit marks registers with an outstanding load. Decode
//   stalls while it reads a busy register.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   rd_en_x/rd_addr_x     read port x (A/B): enable (it gates stall) and index
//   rd_data_x             read port x data (combinational)
//   pc_in                 current PC, returned for reads of PC_IDX
//   wr_en/wr_addr/wr_data writeback port
//   link_en/link_data     BL return-address write into LR_IDX
//   rsv_en/rsv_addr       reserve (mark busy) a load destination
//   pc_write/pc_wdata     redirected PC write (combinational)
//   stall                 a live read hits a busy register (combinational)
//   busy_cnt              registered count of set busy bits
// Config macro: REGFILE_BYPASS_EN forwards same-cycle writeback data to the
//   read ports and clears the matching busy indication.
module arm_regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_IDX = 15,
    parameter int unsigned LR_IDX = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              pc_write,
    output logic [DATA_W-1:0] pc_wdata,
    output logic              stall,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LR_A = ADDR_W'(LR_IDX);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic              busy_a, busy_b;

    // Next state: link first so a same-cycle writeback to LR overrides it;
    // reserve last so a new reservation survives a same-cycle write clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (link_en) begin
            regs_d[LR_A] = link_data;
        end
        if (wr_en && (wr_addr != PC_A)) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != PC_A)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        // PC never becomes busy, so the count saturates naturally at NREG-1.
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read ports: PC alias, array lookup, optional writeback forwarding.
    always_comb begin
        rd_data_a = (rd_addr_a == PC_A) ? pc_in : regs_q[rd_addr_a];
        busy_a    = (rd_addr_a != PC_A) && busy_q[rd_addr_a];
        rd_data_b = (rd_addr_b == PC_A) ? pc_in : regs_q[rd_addr_b];
        busy_b    = (rd_addr_b != PC_A) && busy_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != PC_A)) begin
            rd_data_a = wr_data;
            busy_a    = 1'b0;
        end
        if (wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != PC_A)) begin
            rd_data_b = wr_data;
            busy_b    = 1'b0;
        end
`else
`endif
    end

    assign stall    = (rd_en_a && busy_a) || (rd_en_b && busy_b);
    assign pc_write = wr_en && (wr_addr == PC_A);
    assign pc_wdata = wr_data;
    assign busy_cnt = busy_cnt_q;

endmodule
